// File: rtl/fp_scoreboard_if.sv
// Handshake bundle between a vector driver, the DUT result path and fp_scoreboard.
// The driver side (master) offers expected entries and results; the scoreboard (slave) consumes them.
interface fp_scoreboard_if;
   logic        push_valid;
   logic        push_ready;
   logic [1:0]  push_fmt;
   logic [9:0]  push_opcode;
   logic [63:0] push_result;
   logic [4:0]  push_flags;
   logic        chk_valid;
   logic [63:0] chk_result;
   logic [4:0]  chk_flags;
   logic        done_in;

   modport master (
      output push_valid, push_fmt, push_opcode, push_result, push_flags,
      output chk_valid, chk_result, chk_flags, done_in,
      input  push_ready
   );

   modport slave (
      input  push_valid, push_fmt, push_opcode, push_result, push_flags,
      input  chk_valid, chk_result, chk_flags, done_in,
      output push_ready
   );
endinterface

// File: rtl/fp_scoreboard.sv
// In-order result checker for an FP unit: queues expected entries, compares each returned result
// against the queue head with quiet-NaN payload masking, and keeps pass/fail counters plus a first-failure record.
module fp_scoreboard #(
   parameter int DEPTH        = 8,
   parameter bit STOP_ON_FAIL = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   fp_scoreboard_if.slave     sb_if,
   output logic [31:0]        pass_count_o,
   output logic [31:0]        fail_count_o,
   output logic               fail_o,
   output logic               underflow_o,
   output logic [31:0]        fail_index_o,
   output logic [63:0]        fail_result_diff_o,
   output logic [4:0]         fail_flags_diff_o,
   output logic               finished_o,
   output logic [1:0]         state_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_END = 2'd3} state_t;

   typedef struct packed {
      logic [1:0]  fmt;
      logic [9:0]  opcode;
      logic [63:0] result;
      logic [4:0]  flags;
      logic [31:0] index;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   seq_q, seq_d, pass_q, pass_d, failc_q, failc_d, fidx_q, fidx_d;
   logic [63:0]   frd_q, frd_d;
   logic [4:0]    ffd_q, ffd_d;
   logic          fail_q, fail_d, unf_q, unf_d;
   state_t        state_q, state_d;

   entry_t        head;
   logic [63:0]   rdiff;
   logic [4:0]    fdiff;
   logic          push_ready, push_fire, chk_act, pop, underflow_evt, mismatch, freeze, nan_ok;

   assign push_ready    = (count_q < CW'(DEPTH)) && (state_q == S_IDLE || state_q == S_RUN);
   assign push_fire     = sb_if.push_valid && push_ready;
   assign chk_act       = sb_if.chk_valid && (state_q != S_END);
   assign underflow_evt = chk_act && (count_q == '0);
   assign pop           = chk_act && (count_q != '0);
   assign mismatch      = pop && ((rdiff != 64'h0) || (fdiff != 5'h0));
   assign freeze        = underflow_evt || (mismatch && STOP_ON_FAIL);

   // Canonical quiet NaNs only compare the exponent/quiet bits, since payloads are implementation-defined.
   always_comb begin
      head   = mem_q[rd_ptr_q];
      nan_ok = !head.opcode[9] && !head.opcode[6];
      fdiff  = sb_if.chk_flags ^ head.flags;
      rdiff  = sb_if.chk_result ^ head.result;
      if (nan_ok && head.fmt == 2'd0 && sb_if.chk_result[31:0] == 32'h7FC0_0000) begin
         rdiff = {32'h0, 1'b0, sb_if.chk_result[30:22] ^ head.result[30:22], 22'h0};
      end else if (nan_ok && head.fmt != 2'd0 && sb_if.chk_result == 64'h7FF8_0000_0000_0000) begin
         rdiff = {1'b0, sb_if.chk_result[62:51] ^ head.result[62:51], 51'h0};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      seq_d    = seq_q;
      pass_d   = pass_q;
      failc_d  = failc_q;
      fidx_d   = fidx_q;
      frd_d    = frd_q;
      ffd_d    = ffd_q;
      fail_d   = fail_q;
      unf_d    = unf_q;
      state_d  = state_q;

      if (!freeze) begin
         if (push_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            seq_d    = seq_q + 32'd1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CW'(push_fire) - CW'(pop);
      end

      if (underflow_evt) begin
         unf_d  = 1'b1;
         fail_d = 1'b1;
      end else if (mismatch) begin
         failc_d = (failc_q == 32'hFFFF_FFFF) ? failc_q : failc_q + 32'd1;
         fail_d  = 1'b1;
         if (!fail_q) begin
            fidx_d = head.index;
            frd_d  = rdiff;
            ffd_d  = fdiff;
         end
      end else if (pop) begin
         pass_d = (pass_q == 32'hFFFF_FFFF) ? pass_q : pass_q + 32'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (sb_if.done_in)  state_d = (count_d == '0) ? S_END : S_DRAIN;
            else if (push_fire) state_d = S_RUN;
         end
         S_RUN: begin
            if (sb_if.done_in)  state_d = (count_d == '0) ? S_END : S_DRAIN;
         end
         S_DRAIN: begin
            if (count_d == '0)  state_d = S_END;
         end
         default: state_d = S_END;
      endcase
      if (freeze) state_d = S_END;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         seq_q    <= '0;
         pass_q   <= '0;
         failc_q  <= '0;
         fidx_q   <= '0;
         frd_q    <= '0;
         ffd_q    <= '0;
         fail_q   <= 1'b0;
         unf_q    <= 1'b0;
         state_q  <= S_IDLE;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         seq_q    <= seq_d;
         pass_q   <= pass_d;
         failc_q  <= failc_d;
         fidx_q   <= fidx_d;
         frd_q    <= frd_d;
         ffd_q    <= ffd_d;
         fail_q   <= fail_d;
         unf_q    <= unf_d;
         state_q  <= state_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_fire && !freeze) begin
         mem_q[wr_ptr_q] <= '{fmt: sb_if.push_fmt, opcode: sb_if.push_opcode,
                              result: sb_if.push_result, flags: sb_if.push_flags, index: seq_q};
      end
   end

   assign sb_if.push_ready  = push_ready;
   assign pass_count_o       = pass_q;
   assign fail_count_o       = failc_q;
   assign fail_o             = fail_q;
   assign underflow_o        = unf_q;
   assign fail_index_o       = fidx_q;
   assign fail_result_diff_o = frd_q;
   assign fail_flags_diff_o  = ffd_q;
   assign finished_o         = (state_q == S_END);
   assign state_o            = state_q;
endmodule

// File: tb/tb_fp_scoreboard.sv
// Bench for fp_scoreboard: one stop-on-fail and one count-and-continue instance share the same stimulus,
// a fake FP unit returns queued results after a chosen latency, and counters are checked against a bench model.
module tb_fp_scoreboard;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic        push_valid = 1'b0;
   logic [1:0]  push_fmt = '0;
   logic [9:0]  push_opcode = '0;
   logic [63:0] push_result = '0;
   logic [4:0]  push_flags = '0;
   logic        chk_valid = 1'b0;
   logic [63:0] chk_result = '0;
   logic [4:0]  chk_flags = '0;
   logic        done_in = 1'b0;

   fp_scoreboard_if sb_s ();
   fp_scoreboard_if sb_c ();

   assign sb_s.push_valid = push_valid;   assign sb_c.push_valid = push_valid;
   assign sb_s.push_fmt = push_fmt;       assign sb_c.push_fmt = push_fmt;
   assign sb_s.push_opcode = push_opcode; assign sb_c.push_opcode = push_opcode;
   assign sb_s.push_result = push_result; assign sb_c.push_result = push_result;
   assign sb_s.push_flags = push_flags;   assign sb_c.push_flags = push_flags;
   assign sb_s.chk_valid = chk_valid;     assign sb_c.chk_valid = chk_valid;
   assign sb_s.chk_result = chk_result;   assign sb_c.chk_result = chk_result;
   assign sb_s.chk_flags = chk_flags;     assign sb_c.chk_flags = chk_flags;
   assign sb_s.done_in = done_in;         assign sb_c.done_in = done_in;

   // Index 0 = STOP_ON_FAIL=1 instance, index 1 = STOP_ON_FAIL=0 instance.
   logic [1:0][31:0] pass_cnt, fail_cnt, fidx;
   logic [1:0][63:0] frd;
   logic [1:0][4:0]  ffd;
   logic [1:0][1:0]  st;
   logic [1:0]       fl, unf, fin, rdy;
   assign rdy[0] = sb_s.push_ready;
   assign rdy[1] = sb_c.push_ready;

   fp_scoreboard #(.DEPTH(8), .STOP_ON_FAIL(1'b1)) u_stop (
      .clock(clock), .reset(reset), .sb_if(sb_s),
      .pass_count_o(pass_cnt[0]), .fail_count_o(fail_cnt[0]), .fail_o(fl[0]), .underflow_o(unf[0]),
      .fail_index_o(fidx[0]), .fail_result_diff_o(frd[0]), .fail_flags_diff_o(ffd[0]),
      .finished_o(fin[0]), .state_o(st[0]));

   fp_scoreboard #(.DEPTH(8), .STOP_ON_FAIL(1'b0)) u_cont (
      .clock(clock), .reset(reset), .sb_if(sb_c),
      .pass_count_o(pass_cnt[1]), .fail_count_o(fail_cnt[1]), .fail_o(fl[1]), .underflow_o(unf[1]),
      .fail_index_o(fidx[1]), .fail_result_diff_o(frd[1]), .fail_flags_diff_o(ffd[1]),
      .finished_o(fin[1]), .state_o(st[1]));

   typedef struct {
      logic [1:0]  fmt;
      logic [9:0]  op;
      logic [63:0] er;
      logic [4:0]  ef;
      logic [63:0] cr;
      logic [4:0]  cf;
      bit          pass;
      logic [63:0] rd;
      logic [4:0]  fd;
   } vec_t;

   typedef struct {
      int ti;
      int seq;
   } qent_t;

   vec_t  tbl [12];
   qent_t q [$];
   int    seq;
   int    errors = 0;
   int    checks = 0;

   int          m_pass [2], m_fail [2], m_fidx [2];
   logic [63:0] m_frd [2];
   logic [4:0]  m_ffd [2];
   bit          m_failed [2], m_frozen [2], m_unf [2];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; push_valid = 1'b0; chk_valid = 1'b0; done_in = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      q.delete();
      seq = 0;
      for (int d = 0; d < 2; d++) begin
         m_pass[d] = 0; m_fail[d] = 0; m_fidx[d] = 0; m_frd[d] = '0; m_ffd[d] = '0;
         m_failed[d] = 1'b0; m_frozen[d] = 1'b0; m_unf[d] = 1'b0;
         chk($sformatf("rst_state[%0d]", d), st[d], 0);
         chk($sformatf("rst_ready[%0d]", d), rdy[d], 1);
         chk($sformatf("rst_pass[%0d]", d), pass_cnt[d], 0);
         chk($sformatf("rst_failcnt[%0d]", d), fail_cnt[d], 0);
         chk($sformatf("rst_fail[%0d]", d), fl[d], 0);
         chk($sformatf("rst_underflow[%0d]", d), unf[d], 0);
         chk($sformatf("rst_finished[%0d]", d), fin[d], 0);
         chk($sformatf("rst_fidx[%0d]", d), fidx[d], 0);
         chk($sformatf("rst_frd[%0d]", d), frd[d], 0);
         chk($sformatf("rst_ffd[%0d]", d), ffd[d], 0);
      end
   endtask

   // One clock of stimulus; the returned result comes from the head of the in-flight queue.
   task automatic step(bit pv, int pti, bit cv, bit dn);
      qent_t e;
      bit    empty;
      push_valid = pv;
      if (pv) begin
         push_fmt = tbl[pti].fmt; push_opcode = tbl[pti].op;
         push_result = tbl[pti].er; push_flags = tbl[pti].ef;
      end
      chk_valid = cv;
      done_in   = dn;
      empty     = (q.size() == 0);
      e         = '{0, 0};
      if (cv) begin
         if (empty) begin
            chk_result = '0; chk_flags = '0;
         end else begin
            e = q.pop_front();
            chk_result = tbl[e.ti].cr; chk_flags = tbl[e.ti].cf;
         end
         for (int d = 0; d < 2; d++) begin
            if (!m_frozen[d]) begin
               if (empty) begin
                  m_unf[d] = 1'b1; m_failed[d] = 1'b1; m_frozen[d] = 1'b1;
               end else if (tbl[e.ti].pass) begin
                  m_pass[d]++;
               end else begin
                  m_fail[d]++;
                  if (!m_failed[d]) begin
                     m_fidx[d] = e.seq; m_frd[d] = tbl[e.ti].rd; m_ffd[d] = tbl[e.ti].fd;
                  end
                  m_failed[d] = 1'b1;
                  if (d == 0) m_frozen[d] = 1'b1;
               end
            end
         end
      end
      if (pv && rdy[1]) begin
         q.push_back('{pti, seq});
         seq++;
      end
      @(posedge clock); #1;
      push_valid = 1'b0; chk_valid = 1'b0; done_in = 1'b0;
      if (cv) begin
         $display("chk seq=%0d stop:pass=%0d fail=%0d cont:pass=%0d fail=%0d",
                  e.seq, pass_cnt[0], fail_cnt[0], pass_cnt[1], fail_cnt[1]);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("step_pass[%0d]", d), pass_cnt[d], 64'(m_pass[d]));
            chk($sformatf("step_failcnt[%0d]", d), fail_cnt[d], 64'(m_fail[d]));
         end
      end
   endtask

   task automatic final_check(string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_pass[%0d]", tag, d), pass_cnt[d], 64'(m_pass[d]));
         chk($sformatf("%s_failcnt[%0d]", tag, d), fail_cnt[d], 64'(m_fail[d]));
         chk($sformatf("%s_fail[%0d]", tag, d), fl[d], 64'(m_failed[d]));
         chk($sformatf("%s_underflow[%0d]", tag, d), unf[d], 64'(m_unf[d]));
         chk($sformatf("%s_fidx[%0d]", tag, d), fidx[d], 64'(m_fidx[d]));
         chk($sformatf("%s_frd[%0d]", tag, d), frd[d], m_frd[d]);
         chk($sformatf("%s_ffd[%0d]", tag, d), ffd[d], 64'(m_ffd[d]));
      end
   endtask

   // mode 0: no done_in; 1: done_in with the last push; 2: done_in with the last returned result
   task automatic run_stream(int start, int n, int lat, int mode);
      for (int c = 0; c < n + lat; c++) begin
         bit pv, cv, dn;
         pv = (c < n);
         cv = (c >= lat);
         dn = (mode == 1 && c == n - 1) || (mode == 2 && c == n - 1 + lat);
         step(pv, pv ? start + c : 0, cv, dn);
         if (mode == 1 && c == n - 1) chk("drain_state", st[1], 2);
         if (mode == 2 && c == n - 1 + lat) chk("direct_end_state", st[1], 3);
      end
   endtask

   initial begin
      tbl[0]  = '{2'd0, 10'h001, 64'h7FC0_0001, 5'h00, 64'h7FC0_0000, 5'h00, 1'b1, 64'h0, 5'h00};
      tbl[1]  = '{2'd1, 10'h001, 64'h7FF8_0000_0000_0123, 5'h00, 64'h7FF8_0000_0000_0000, 5'h00, 1'b1, 64'h0, 5'h00};
      tbl[2]  = '{2'd0, 10'h001, 64'h3F80_0000, 5'h01, 64'h3F80_0000, 5'h00, 1'b0, 64'h0, 5'h01};
      tbl[3]  = '{2'd1, 10'h002, 64'h4009_21FB_5444_2D18, 5'h01, 64'h4009_21FB_5444_2D18, 5'h01, 1'b1, 64'h0, 5'h00};
      tbl[4]  = '{2'd0, 10'h040, 64'h7FC0_0001, 5'h00, 64'h7FC0_0000, 5'h00, 1'b0, 64'h1, 5'h00};
      tbl[5]  = '{2'd0, 10'h001, 64'h3F80_0000, 5'h00, 64'h3F80_0000, 5'h00, 1'b1, 64'h0, 5'h00};
      tbl[6]  = '{2'd1, 10'h004, 64'h4009_21FB_5444_2D18, 5'h01, 64'h4009_21FB_5444_2D18, 5'h01, 1'b1, 64'h0, 5'h00};
      tbl[7]  = '{2'd0, 10'h040, 64'h1, 5'h10, 64'h1, 5'h10, 1'b1, 64'h0, 5'h00};
      tbl[8]  = '{2'd1, 10'h200, 64'h2A, 5'h10, 64'h2A, 5'h10, 1'b1, 64'h0, 5'h00};
      tbl[9]  = '{2'd0, 10'h002, 64'h7FC0_0000, 5'h10, 64'h7FC0_0000, 5'h10, 1'b1, 64'h0, 5'h00};
      tbl[10] = tbl[0];
      tbl[11] = tbl[4];

      // Empty stream: done_in straight from IDLE ends with a pass.
      do_reset();
      step(1'b0, 0, 1'b0, 1'b1);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("empty_state[%0d]", d), st[d], 3);
         chk($sformatf("empty_finished[%0d]", d), fin[d], 1);
      end
      final_check("empty");

      // Three exact matches, latency 4, done_in with the final result.
      do_reset();
      run_stream(5, 3, 4, 2);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("exact_state[%0d]", d), st[d], 3);
         chk($sformatf("exact_finished[%0d]", d), fin[d], 1);
      end
      final_check("exact");

      // NaN payload masking on, then disabled by an fcmp opcode.
      do_reset();
      run_stream(10, 2, 2, 1);
      chk("nan_state_cont", st[1], 3);
      final_check("nan");

      // Ten entries, two mismatches (index 2 flags, index 4 fcmp payload).
      do_reset();
      run_stream(0, 10, 4, 1);
      for (int d = 0; d < 2; d++) chk($sformatf("mix_state[%0d]", d), st[d], 3);
      final_check("mix");

      // Fill to DEPTH, push+pop at count 7, drain, then underflow.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 5 + (i % 5), 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) chk($sformatf("full_ready[%0d]", d), rdy[d], 0);
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b1, 5, 1'b1, 1'b0);
      for (int d = 0; d < 2; d++) chk($sformatf("cnt7_ready[%0d]", d), rdy[d], 1);
      step(1'b1, 6, 1'b0, 1'b0);
      for (int d = 0; d < 2; d++) chk($sformatf("refull_ready[%0d]", d), rdy[d], 0);
      for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1, 1'b0);
      for (int d = 0; d < 2; d++) chk($sformatf("drained_ready[%0d]", d), rdy[d], 1);
      step(1'b0, 0, 1'b1, 1'b0);
      for (int d = 0; d < 2; d++) chk($sformatf("unf_state[%0d]", d), st[d], 3);
      final_check("fill");

      // Reset mid-stream discards in-flight entries: the next result underflows.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 5 + i, 1'b0, 1'b0);
      do_reset();
      step(1'b0, 0, 1'b1, 1'b0);
      final_check("midrst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fp_scoreboard.md
FP_SCOREBOARD -- requirements
Module: fp_scoreboard

Interface
REQ-001 Parameter DEPTH, default 8, expected-entry queue depth, power of two, 2..64.
REQ-002 Parameter STOP_ON_FAIL, default 1, 1 = freeze on first mismatch, 0 = count and continue.
REQ-003 clock  in  1  clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low.
REQ-005 push_valid  in  1  expected entry offered, same cycle the vector is issued to fp_unit.
REQ-006 push_ready  out  1  entry accepted when push_valid && push_ready.
REQ-007 push_fmt  in  2  format (0 = single, other = double); push_opcode  in  10  one-hot opcode (bit6 fcmp, bit9 fcvt_f2i).
REQ-008 push_result  in  64 / push_flags  in  5  reference result and flags.
REQ-009 chk_valid  in  1  fp_unit_o.fp_exe_o.ready; chk_result  in  64; chk_flags  in  5.
REQ-010 done_in  in  1  end of vector stream, single-cycle pulse.
REQ-011 pass_count / fail_count  out  32 each  compared-entry counters.
REQ-012 fail  out  1  sticky mismatch or protocol error; underflow  out  1  sticky, chk_valid with empty queue.
REQ-013 fail_index  out  32 / fail_result_diff  out  64 / fail_flags_diff  out  5  first failing entry record.
REQ-014 finished  out  1  high in DONE or FAIL; state  out  2  IDLE=0, RUN=1, DRAIN=2, END=3.

Function
REQ-015 Queue: FIFO of DEPTH entries {fmt, opcode, result, flags, index}; index = 32-bit push sequence number starting at 0.
REQ-016 push_ready = (count < DEPTH) && state in {IDLE, RUN}; no push accepted in DRAIN or END.
REQ-017 Each chk_valid cycle compares chk_* with queue head combinationally and pops head at the same edge; zero added latency, any DUT latency tolerated up to DEPTH in flight.
REQ-018 Simultaneous push and pop: count unchanged, both take effect; pointers wrap modulo DEPTH.
REQ-019 Diff rule, opcode[9]==0 && opcode[6]==0 && fmt==0 && chk_result[31:0]==32'h7FC00000: result_diff = {32'h0, 1'b0, chk[30:22]^exp[30:22], 22'h0}.
REQ-020 Diff rule, same opcode condition && fmt!=0 && chk_result==64'h7FF8000000000000: result_diff = {1'b0, chk[62:51]^exp[62:51], 51'h0}.
REQ-021 Otherwise result_diff = chk_result ^ exp_result; flags_diff = chk_flags ^ exp_flags always.
REQ-022 Entry passes iff result_diff==0 && flags_diff==0; pass_count or fail_count increments at that edge, saturating at 32'hFFFFFFFF.
REQ-023 First failure only: fail_index, fail_result_diff, fail_flags_diff latched at that edge; later failures update counts only.
REQ-024 FSM: IDLE->RUN on first accepted push; RUN->DRAIN on done_in; IDLE->END on done_in (empty stream, pass); DRAIN->END when count==0 after pops.
REQ-025 done_in and last pop in same cycle with queue becoming empty: RUN->END directly.
REQ-026 Mismatch with STOP_ON_FAIL=1: state->END, fail=1, queue frozen, further chk_valid ignored, counters held.
REQ-027 chk_valid with count==0 (no simultaneous push counted): underflow=1, fail=1, state->END regardless of STOP_ON_FAIL, no counter change.
REQ-028 push_valid when !push_ready: entry dropped, no error; producer must hold.
REQ-029 END is absorbing until reset; finished=1 in END.

Reset
REQ-030 reset==0 at a rising edge: state=IDLE, queue empty, pointers and index=0, counters=0, fail=0, underflow=0, fail_index=0, diffs=0, push_ready=1 next cycle; reset mid-stream discards all in-flight entries.

Verification
REQ-031 3 pushes, DUT latency 4, exact matches, done_in -> pass_count=3, fail_count=0, finished=1, fail=0.
REQ-032 fmt=0 fadd, expected 32'h7FC00001, chk 32'h7FC00000, flags equal -> pass (payload masked); same with opcode[6]=1 -> fail, fail_result_diff=64'h1.
REQ-033 STOP_ON_FAIL=1, entry index 2 flags exp 5'h01 chk 5'h00 -> fail=1, fail_index=2, fail_flags_diff=5'h01, state=END, later chk ignored.
REQ-034 STOP_ON_FAIL=0, 10 entries, 2 mismatches -> pass_count=8, fail_count=2, fail_index=first mismatch, END after drain.
REQ-035 DEPTH=8, 8 pushes no chk -> push_ready=0; push+chk same cycle at count=7 -> count stays 7; chk_valid with empty queue -> underflow=1, fail=1.
